// File: rtl/ex_stage_unit_if.sv
// Decode <-> execute bus bundle: decoded op in, registered result and hazard info out.
interface ex_stage_unit_if;
  logic [55:0] idbus;
  logic        stall;
  logic [39:0] exbus;
  logic [2:0]  ex_dest;

  // Decode side drives idbus and observes stall/exbus/ex_dest.
  modport master (
    output idbus,
    input  stall,
    input  exbus,
    input  ex_dest
  );

  // Execute side.
  modport slave (
    input  idbus,
    output stall,
    output exbus,
    output ex_dest
  );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU ops plus 16-iteration shift-add multiply and
// restoring divide/remainder, stalling decode while an iterative op is in flight.
module ex_stage_unit #(
  parameter int unsigned     DW        = 16,
  parameter logic [DW-1:0]   DIV0_QUOT = 16'hFFFF
) (
  input  logic            clock,
  input  logic            reset,
  ex_stage_unit_if.slave  ex_bus
);

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpSra  = 4'd8;
  localparam logic [3:0] OpMul  = 4'd9;
  localparam logic [3:0] OpDivu = 4'd10;
  localparam logic [3:0] OpRemu = 4'd11;
  localparam logic [3:0] OpLd   = 4'd12;
  localparam logic [3:0] OpSt   = 4'd13;
  localparam logic [3:0] OpSlt  = 4'd14;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    dest_q, dest_d;
  logic [DW-1:0] acc_q, acc_d;   // product accumulator / partial remainder
  logic [DW-1:0] a_q, a_d;       // multiplier / dividend-then-quotient
  logic [DW-1:0] b_q, b_d;       // multiplicand / divisor
  logic [39:0]   exbus_q, exbus_d;

  logic          id_valid;
  logic [3:0]    id_op;
  logic [2:0]    id_dest;
  logic [DW-1:0] id_v1, id_v2, id_st;
  logic          id_iter;

  assign id_valid = ex_bus.idbus[55];
  assign id_op    = ex_bus.idbus[54:51];
  assign id_dest  = ex_bus.idbus[50:48];
  assign id_v1    = ex_bus.idbus[47:32];
  assign id_v2    = ex_bus.idbus[31:16];
  assign id_st    = ex_bus.idbus[15:0];
  assign id_iter  = (id_op == OpMul) || (id_op == OpDivu) || (id_op == OpRemu);

  logic [DW-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (id_op)
      OpAdd, OpLd, OpSt: alu_res = id_v1 + id_v2;
      OpSub:             alu_res = id_v1 - id_v2;
      OpAnd:             alu_res = id_v1 & id_v2;
      OpOr:              alu_res = id_v1 | id_v2;
      OpXor:             alu_res = id_v1 ^ id_v2;
      OpSll:             alu_res = id_v1 << id_v2[3:0];
      OpSrl:             alu_res = id_v1 >> id_v2[3:0];
      OpSra:             alu_res = $signed(id_v1) >>> id_v2[3:0];
      OpSlt:             alu_res = {{(DW-1){1'b0}}, ($signed(id_v1) < $signed(id_v2))};
      default:           alu_res = '0;
    endcase
  end

  // Restoring-division trial subtract; bit DW set means the subtraction borrowed.
  logic [DW:0]   trial;
  logic [DW-1:0] mul_acc;
  assign trial   = {acc_q, a_q[DW-1]} - {1'b0, b_q};
  assign mul_acc = acc_q + (a_q[0] ? b_q : '0);

  logic [DW-1:0] iter_res;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dest_d   = dest_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    exbus_d  = exbus_q;
    iter_res = '0;
    unique case (state_q)
      StIdle: begin
        if (!id_valid) begin
          exbus_d = '0;
        end else if (id_iter) begin
          state_d = StBusy;
          cnt_d   = '0;
          op_d    = id_op;
          dest_d  = id_dest;
          acc_d   = '0;
          a_d     = (id_op == OpMul) ? id_v2 : id_v1;
          b_d     = (id_op == OpMul) ? id_v1 : id_v2;
          exbus_d = '0;
        end else if (id_op == OpNop || id_op == 4'd15) begin
          exbus_d = {1'b1, id_op, 3'd0, 32'd0};
        end else begin
          exbus_d = {1'b1, id_op, id_dest, alu_res, (id_op == OpSt) ? id_st : {DW{1'b0}}};
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 4'd1;
        if (op_q == OpMul) begin
          acc_d = mul_acc;
          a_d   = a_q >> 1;
          b_d   = b_q << 1;
        end else if (!trial[DW]) begin
          acc_d = trial[DW-1:0];
          a_d   = {a_q[DW-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[DW-2:0], a_q[DW-1]};
          a_d   = {a_q[DW-2:0], 1'b0};
        end
        if (op_q == OpDivu) begin
          iter_res = (b_q == '0) ? DIV0_QUOT : a_d;
        end else begin
          iter_res = acc_d;
        end
        if (cnt_q == 4'd15) begin
          state_d = StIdle;
          exbus_d = {1'b1, op_q, dest_q, iter_res, {DW{1'b0}}};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exbus_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exbus_q <= exbus_d;
    end
  end

  assign ex_bus.stall   = (state_q == StBusy);
  assign ex_bus.exbus   = exbus_q;
  assign ex_bus.ex_dest = (state_q == StBusy) ? dest_q :
                          exbus_q[39]         ? exbus_q[34:32] : 3'd0;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: arithmetic reference model plus directed vectors.
module tb_ex_stage_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ex_stage_unit_if bus ();

  ex_stage_unit #(
    .DW        (16),
    .DIV0_QUOT (16'hFFFF)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ex_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] pack(input logic [3:0] op, input logic [2:0] d,
                                       input logic [15:0] r, input logic [15:0] s);
    return {1'b1, op, d, r, s};
  endfunction

  // Reference result of one decoded instruction, from the op definitions.
  function automatic logic [39:0] expect_ex(input logic [55:0] id);
    logic [3:0]  op;
    logic [2:0]  d;
    logic [15:0] v1, v2, st, r;
    logic [31:0] prod;
    op = id[54:51]; d = id[50:48]; v1 = id[47:32]; v2 = id[31:16]; st = id[15:0];
    prod = v1 * v2;
    r = 16'h0;
    case (op)
      4'd1, 4'd12, 4'd13: r = v1 + v2;
      4'd2:  r = v1 - v2;
      4'd3:  r = v1 & v2;
      4'd4:  r = v1 | v2;
      4'd5:  r = v1 ^ v2;
      4'd6:  r = v1 << v2[3:0];
      4'd7:  r = v1 >> v2[3:0];
      4'd8:  r = $signed(v1) >>> v2[3:0];
      4'd9:  r = prod[15:0];
      4'd10: r = (v2 == 0) ? 16'hFFFF : v1 / v2;
      4'd11: r = (v2 == 0) ? v1 : v1 % v2;
      4'd14: r = ($signed(v1) < $signed(v2)) ? 16'd1 : 16'd0;
      default: r = 16'h0;
    endcase
    if (op == 4'd0 || op == 4'd15) return pack(op, 3'd0, 16'h0, 16'h0);
    return pack(op, d, r, (op == 4'd13) ? st : 16'h0);
  endfunction

  // Cycle model: m_cnt is the number of edges left before an iterative result lands.
  logic [39:0] m_exbus = '0;
  logic [39:0] m_pend  = '0;
  logic [2:0]  m_dest  = '0;
  int          m_cnt   = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_exbus <= '0;
      m_cnt   <= 0;
      m_dest  <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_exbus <= m_pend;
    end else if (!bus.idbus[55]) begin
      m_exbus <= '0;
    end else if (bus.idbus[54:51] >= 4'd9 && bus.idbus[54:51] <= 4'd11) begin
      m_cnt   <= 16;
      m_dest  <= bus.idbus[50:48];
      m_pend  <= expect_ex(bus.idbus);
      m_exbus <= '0;
    end else begin
      m_exbus <= expect_ex(bus.idbus);
    end
  end

  always @(negedge clock) begin
    logic [2:0] exp_dest;
    exp_dest = (m_cnt > 0) ? m_dest : (m_exbus[39] ? m_exbus[34:32] : 3'd0);
    check("model_exbus", bus.exbus, m_exbus);
    check("model_stall", {39'd0, bus.stall}, {39'd0, (m_cnt > 0)});
    check("model_ex_dest", {37'd0, bus.ex_dest}, {37'd0, exp_dest});
  end

  task automatic send(input logic [3:0] op, input logic [2:0] d, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] st);
    bus.idbus = {1'b1, op, d, v1, v2, st};
    @(negedge clock);
  endtask

  task automatic idle();
    bus.idbus = '0;
  endtask

  task automatic iter_op(input logic [3:0] op, input logic [2:0] d, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] exp, input string name);
    send(op, d, v1, v2, 16'h0);
    idle();
    check({name, "_stall"}, {39'd0, bus.stall}, 40'd1);
    repeat (16) @(negedge clock);
    check(name, bus.exbus, pack(op, d, exp, 16'h0));
  endtask

  initial begin
    bus.idbus = '0;
    repeat (2) @(negedge clock);
    check("reset_exbus", bus.exbus, 40'd0);
    check("reset_stall", {39'd0, bus.stall}, 40'd0);
    reset = 1'b1;

    send(4'd1, 3'd3, 16'h7FFF, 16'h0001, 16'h0);
    check("add_ovf", bus.exbus, pack(4'd1, 3'd3, 16'h8000, 16'h0));
    check("add_dest", {37'd0, bus.ex_dest}, 40'd3);

    send(4'd1, 3'd1, 16'h0005, 16'h0003, 16'h0);
    check("b2b_add", bus.exbus, pack(4'd1, 3'd1, 16'h0008, 16'h0));
    send(4'd2, 3'd2, 16'h0005, 16'h0003, 16'h0);
    check("b2b_sub", bus.exbus, pack(4'd2, 3'd2, 16'h0002, 16'h0));
    send(4'd14, 3'd4, 16'hFFFF, 16'h0001, 16'h0);
    check("b2b_slt", bus.exbus, pack(4'd14, 3'd4, 16'h0001, 16'h0));
    check("b2b_nostall", {39'd0, bus.stall}, 40'd0);

    send(4'd9, 3'd2, 16'h0123, 16'h0045, 16'h0);
    bus.idbus = {1'b1, 4'd1, 3'd5, 16'h0001, 16'h0001, 16'h0};
    check("mul_dest", {37'd0, bus.ex_dest}, 40'd2);
    check("mul_novalid", {39'd0, bus.exbus[39]}, 40'd0);
    repeat (15) begin
      @(negedge clock);
      check("mul_stall", {39'd0, bus.stall}, 40'd1);
    end
    @(negedge clock);
    check("mul_result", bus.exbus, pack(4'd9, 3'd2, 16'h4E6F, 16'h0));
    check("mul_unstall", {39'd0, bus.stall}, 40'd0);
    @(negedge clock);
    check("held_add", bus.exbus, pack(4'd1, 3'd5, 16'h0002, 16'h0));
    idle();
    @(negedge clock);
    check("idle_zero", bus.exbus, 40'd0);

    iter_op(4'd10, 3'd1, 16'h0064, 16'h0007, 16'h000E, "divu");
    iter_op(4'd11, 3'd6, 16'h0064, 16'h0007, 16'h0002, "remu");
    iter_op(4'd10, 3'd3, 16'h1234, 16'h0000, 16'hFFFF, "divu_zero");
    iter_op(4'd11, 3'd7, 16'h1234, 16'h0000, 16'h1234, "remu_zero");
    iter_op(4'd9, 3'd1, 16'hFFFF, 16'hFFFF, 16'h0001, "mul_wrap");

    send(4'd8, 3'd1, 16'h8000, 16'h0014, 16'h0);
    check("sra", bus.exbus, pack(4'd8, 3'd1, 16'hF800, 16'h0));
    send(4'd7, 3'd2, 16'h8000, 16'h0014, 16'h0);
    check("srl", bus.exbus, pack(4'd7, 3'd2, 16'h0800, 16'h0));
    send(4'd13, 3'd0, 16'h0100, 16'h0004, 16'hBEEF);
    check("st", bus.exbus, pack(4'd13, 3'd0, 16'h0104, 16'hBEEF));
    send(4'd12, 3'd4, 16'h0100, 16'h0004, 16'hBEEF);
    check("ld", bus.exbus, pack(4'd12, 3'd4, 16'h0104, 16'h0));
    send(4'd15, 3'd6, 16'h1111, 16'h2222, 16'h3333);
    check("reserved", bus.exbus, pack(4'd15, 3'd0, 16'h0, 16'h0));
    send(4'd6, 3'd3, 16'h00F1, 16'h0004, 16'h0);
    check("sll", bus.exbus, pack(4'd6, 3'd3, 16'h0F10, 16'h0));
    send(4'd5, 3'd2, 16'hF0F0, 16'h0FF0, 16'h0);
    check("xor", bus.exbus, pack(4'd5, 3'd2, 16'hFF00, 16'h0));

    send(4'd9, 3'd2, 16'h0123, 16'h0045, 16'h0);
    idle();
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_exbus", bus.exbus, 40'd0);
    check("rst_stall", {39'd0, bus.stall}, 40'd0);
    check("rst_dest", {37'd0, bus.ex_dest}, 40'd0);
    @(negedge clock);
    bus.idbus = {1'b1, 4'd1, 3'd1, 16'h0001, 16'h0001, 16'h0};
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_add", bus.exbus, pack(4'd1, 3'd1, 16'h0002, 16'h0));
    idle();
    repeat (20) begin
      @(negedge clock);
      check("no_mul_after_rst", {39'd0, bus.exbus[39]}, 40'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
